panel_input_conditioner: RTL and testbench

//  Front-panel input stage that feeds the CPU top level. It takes the raw FPGA GPIO from the

---
 rtl/panel_input_conditioner.sv | 192 +++++++++++++++++++
 tb/tb_panel_input_conditioner.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/panel_input_conditioner.sv
// rtl/panel_input_conditioner.sv - front-panel button/switch synchroniser and debouncer
//
// Config macro: PANEL_ACTIVE_LOW_BTN_EN (buttons inverted before the synchroniser).
// Ports:
//   sys_clk, rst          clock, asynchronous active-high reset
//   btn_clk_raw           raw manual-clock button
//   btn_ram_raw           raw RAM-program button
//   sw_clk_mode_raw       raw clock-mode switch
//   sw_ram_mode_raw       raw RAM-program-mode switch
//   sw_addr_raw[3:0]      raw MAR address switches
//   sw_data_raw[7:0]      raw RAM data switches
//   clk_pulse/ram_pulse   debounced button levels
//   *_rise                one-cycle strobes on debounced press
//   clk_mode/ram_mode     debounced mode switches
//   mar_address/ram_data  debounced address/data group (updated together)

// Stability counter for one channel. The owner holds the accepted value and
// loads the synced value when load is high.
module panel_debounce #(
   parameter int WIDTH  = 1,
   parameter int CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] synced,
   input  logic [WIDTH-1:0] accepted,
   output logic             load
);
   localparam int CW = $clog2(CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
   localparam logic [CW-1:0] MAX  = '1;

   logic [WIDTH-1:0] prev;
   logic [CW-1:0]    count;
   logic             differs;
   logic             stable;

   assign differs = (synced != accepted);
   assign stable  = (synced == prev);
   // Accept only once the differing value has been steady for CYCLES cycles.
   assign load    = differs && stable && (count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev  <= '0;
         count <= '0;
      end else begin
         prev <= synced;
         if (!differs || !stable || load)
            count <= '0;
         else if (count != MAX)
            count <= count + CW'(1);
      end
   end
endmodule

// Debounced button: the FSM state is the accepted level.
module panel_button #(
   parameter int CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic synced,
   output logic level,
   output logic rise
);
   typedef enum logic [1:0] {LOW, RISE_PEND, HIGH, FALL_PEND} btn_state_t;

   btn_state_t state, next;
   logic       load;

   assign level = (state == HIGH) || (state == FALL_PEND);

   panel_debounce #(.WIDTH(1), .CYCLES(CYCLES)) u_db (
      .clk      (clk),
      .rst      (rst),
      .synced   (synced),
      .accepted (level),
      .load     (load)
   );

   always_comb begin
      next = state;
      case (state)
         LOW:       if (synced) next = RISE_PEND;
         RISE_PEND: if (load) next = HIGH;
                    else if (!synced) next = LOW;
         HIGH:      if (!synced) next = FALL_PEND;
         FALL_PEND: if (load) next = LOW;
                    else if (synced) next = HIGH;
         default:   next = LOW;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LOW;
         rise  <= 1'b0;
      end else begin
         state <= next;
         rise  <= (state == RISE_PEND) && (next == HIGH);
      end
   end
endmodule

module panel_input_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 270000
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       btn_clk_raw,
   input  logic       btn_ram_raw,
   input  logic       sw_clk_mode_raw,
   input  logic       sw_ram_mode_raw,
   input  logic [3:0] sw_addr_raw,
   input  logic [7:0] sw_data_raw,
   output logic       clk_pulse,
   output logic       clk_pulse_rise,
   output logic       ram_pulse,
   output logic       ram_pulse_rise,
   output logic       clk_mode,
   output logic       ram_mode,
   output logic [3:0] mar_address,
   output logic [7:0] ram_data
);
   // Bit map: [15] btn_clk, [14] btn_ram, [13] clk_mode, [12] ram_mode,
   //          [11:8] address, [7:0] data.
   logic [1:0]  btn_in;
   logic [15:0] raw_vec;
   logic [15:0] sync_q [SYNC_STAGES];
   logic [15:0] synced;
   logic        load_clk_mode, load_ram_mode, load_group;

`ifdef PANEL_ACTIVE_LOW_BTN_EN
   // Invert ahead of the chain so a reset chain (0) still means "released".
   assign btn_in = ~{btn_clk_raw, btn_ram_raw};
`else
   assign btn_in = {btn_clk_raw, btn_ram_raw};
`endif

   assign raw_vec = {btn_in, sw_clk_mode_raw, sw_ram_mode_raw, sw_addr_raw, sw_data_raw};
   assign synced  = sync_q[SYNC_STAGES-1];

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= raw_vec;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   panel_button #(.CYCLES(DEBOUNCE_CYCLES)) u_btn_clk (
      .clk (sys_clk), .rst (rst), .synced (synced[15]),
      .level (clk_pulse), .rise (clk_pulse_rise)
   );

   panel_button #(.CYCLES(DEBOUNCE_CYCLES)) u_btn_ram (
      .clk (sys_clk), .rst (rst), .synced (synced[14]),
      .level (ram_pulse), .rise (ram_pulse_rise)
   );

   panel_debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_db_clk_mode (
      .clk (sys_clk), .rst (rst), .synced (synced[13]),
      .accepted (clk_mode), .load (load_clk_mode)
   );

   panel_debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_db_ram_mode (
      .clk (sys_clk), .rst (rst), .synced (synced[12]),
      .accepted (ram_mode), .load (load_ram_mode)
   );

   // Address and data share one counter so they can only change together.
   panel_debounce #(.WIDTH(12), .CYCLES(DEBOUNCE_CYCLES)) u_db_group (
      .clk (sys_clk), .rst (rst), .synced (synced[11:0]),
      .accepted ({mar_address, ram_data}), .load (load_group)
   );

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         clk_mode    <= 1'b0;
         ram_mode    <= 1'b0;
         mar_address <= '0;
         ram_data    <= '0;
      end else begin
         if (load_clk_mode) clk_mode <= synced[13];
         if (load_ram_mode) ram_mode <= synced[12];
         if (load_group) {mar_address, ram_data} <= synced[11:0];
      end
   end
endmodule

// File: tb/tb_panel_input_conditioner.sv
// tb/tb_panel_input_conditioner.sv - directed bench for panel_input_conditioner
module tb_panel_input_conditioner;
   logic       sys_clk = 1'b0;
   logic       rst;
   logic       btn_clk_raw, btn_ram_raw, sw_clk_mode_raw, sw_ram_mode_raw;
   logic [3:0] sw_addr_raw;
   logic [7:0] sw_data_raw;
   logic       clk_pulse, clk_pulse_rise, ram_pulse, ram_pulse_rise;
   logic       clk_mode, ram_mode;
   logic [3:0] mar_address;
   logic [7:0] ram_data;

   int   checks = 0;
   int   errors = 0;
   int   n_clk_rise = 0;
   int   n_ram_rise = 0;
   int   n_double = 0;
   int   base_clk, base_ram;
   logic prev_cr = 1'b0;
   logic prev_rr = 1'b0;
   logic on;

   panel_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
      .sys_clk         (sys_clk),
      .rst             (rst),
      .btn_clk_raw     (btn_clk_raw),
      .btn_ram_raw     (btn_ram_raw),
      .sw_clk_mode_raw (sw_clk_mode_raw),
      .sw_ram_mode_raw (sw_ram_mode_raw),
      .sw_addr_raw     (sw_addr_raw),
      .sw_data_raw     (sw_data_raw),
      .clk_pulse       (clk_pulse),
      .clk_pulse_rise  (clk_pulse_rise),
      .ram_pulse       (ram_pulse),
      .ram_pulse_rise  (ram_pulse_rise),
      .clk_mode        (clk_mode),
      .ram_mode        (ram_mode),
      .mar_address     (mar_address),
      .ram_data        (ram_data)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
         if (clk_pulse_rise) n_clk_rise++;
         if (ram_pulse_rise) n_ram_rise++;
         if ((clk_pulse_rise && prev_cr) || (ram_pulse_rise && prev_rr)) n_double++;
         prev_cr = clk_pulse_rise;
         prev_rr = ram_pulse_rise;
      end
   endtask

   initial begin
`ifdef PANEL_ACTIVE_LOW_BTN_EN
      on = 1'b0;
`else
      on = 1'b1;
`endif
      rst = 1'b1;
      btn_clk_raw = ~on;
      btn_ram_raw = ~on;
      sw_clk_mode_raw = 1'b0;
      sw_ram_mode_raw = 1'b0;
      sw_addr_raw = 4'h0;
      sw_data_raw = 8'h00;
      step(2);
      check("rst_clk_pulse", clk_pulse, 1'b0);
      check("rst_ram_pulse", ram_pulse, 1'b0);
      check("rst_rises", {clk_pulse_rise, ram_pulse_rise}, 2'b00);
      check("rst_modes", {clk_mode, ram_mode}, 2'b00);
      check("rst_group", {mar_address, ram_data}, 12'h000);
      rst = 1'b0;
      step(3);
      check("idle_clk_pulse", clk_pulse, 1'b0);

      // Clean press with mode switches flipping at the same time
      base_clk = n_clk_rise;
      btn_clk_raw = on;
      sw_clk_mode_raw = 1'b1;
      sw_ram_mode_raw = 1'b1;
      step(6);
      check("press_before", clk_pulse, 1'b0);
      check("mode_before", clk_mode, 1'b0);
      step(1);
      check("press_level", clk_pulse, 1'b1);
      check("press_rise", clk_pulse_rise, 1'b1);
      check("mode_after", {clk_mode, ram_mode}, 2'b11);
      step(1);
      check("press_rise_off", clk_pulse_rise, 1'b0);
      check("press_hold", clk_pulse, 1'b1);
      step(12);
      btn_clk_raw = ~on;
      step(6);
      check("release_before", clk_pulse, 1'b1);
      step(1);
      check("release_level", clk_pulse, 1'b0);
      check("release_no_rise", clk_pulse_rise, 1'b0);
      step(3);
      check("press_rise_count", n_clk_rise - base_clk, 1);

      // Bounce: zeros at indices 3 and 6, last 0->1 at index 7
      base_ram = n_ram_rise;
      for (int i = 0; i < 20; i++) begin
         btn_ram_raw = (i == 3 || i == 6) ? ~on : on;
         step(1);
         if (i < 13) check("bounce_hold", ram_pulse, 1'b0);
         if (i == 13) begin
            check("bounce_level", ram_pulse, 1'b1);
            check("bounce_rise", ram_pulse_rise, 1'b1);
         end
      end
      check("bounce_rise_count", n_ram_rise - base_ram, 1);
      btn_ram_raw = ~on;
      step(8);
      check("bounce_release", ram_pulse, 1'b0);

      // Group atomicity with a one-cycle glitch on data bit 0
      for (int i = 0; i < 12; i++) begin
         sw_addr_raw = 4'h9;
         sw_data_raw = (i == 1) ? 8'hA4 : 8'hA5;
         step(1);
         check("group_atomic", {mar_address, ram_data}, (i >= 8) ? 12'h9A5 : 12'h000);
      end

      // Reset in the middle of a button count
      btn_clk_raw = on;
      step(5);
      rst = 1'b1;
      #1;
      check("async_rst_mode", clk_mode, 1'b0);
      check("async_rst_group", {mar_address, ram_data}, 12'h000);
      check("async_rst_pulse", clk_pulse, 1'b0);
      step(2);
      check("in_rst_pulse", clk_pulse, 1'b0);
      rst = 1'b0;
      base_clk = n_clk_rise;
      step(6);
      check("requal_before", clk_pulse, 1'b0);
      step(1);
      check("requal_level", clk_pulse, 1'b1);
      check("requal_rise", clk_pulse_rise, 1'b1);
      check("requal_mode", clk_mode, 1'b1);
      check("requal_group", {mar_address, ram_data}, 12'h9A5);
      step(4);
      check("requal_rise_count", n_clk_rise - base_clk, 1);

      // Simultaneous presses while the clock-mode switch chatters
      btn_clk_raw = ~on;
      step(8);
      check("pre_sim_level", {clk_pulse, ram_pulse}, 2'b00);
      base_clk = n_clk_rise;
      base_ram = n_ram_rise;
      btn_clk_raw = on;
      btn_ram_raw = on;
      for (int i = 0; i < 10; i++) begin
         sw_clk_mode_raw = (i % 2 == 1);
         step(1);
         check("sim_mode_steady", clk_mode, 1'b1);
         if (i == 6) check("sim_both_rise", {clk_pulse_rise, ram_pulse_rise}, 2'b11);
      end
      check("sim_clk_count", n_clk_rise - base_clk, 1);
      check("sim_ram_count", n_ram_rise - base_ram, 1);
      check("no_double_strobe", n_double, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
